// File: rtl/reg_file_8x8.sv
// Eight-entry register file: two combinational read ports, one synchronous write port.
// Define REGFILE_BYPASS_EN for write-first forwarding; default build reads the stored value.
module reg_file_8x8 #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ra,
  input  logic [ADDR_W-1:0] rb,
  input  logic [ADDR_W-1:0] wa,
  input  logic              we,
  input  logic [DATA_W-1:0] wd,
  output logic [DATA_W-1:0] rd_a,
  output logic [DATA_W-1:0] rd_b
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];

  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      if (we && (wa == ADDR_W'(i))) begin
        regs_d[i] = wd;
      end else begin
        regs_d[i] = regs_q[i];
      end
    end
  end

  // Reset outranks a same-cycle write, which is simply dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= {DATA_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

`ifdef REGFILE_BYPASS_EN
  always_comb begin
    if (we && !rst && (wa == ra)) begin
      rd_a = wd;
    end else begin
      rd_a = regs_q[ra];
    end
    if (we && !rst && (wa == rb)) begin
      rd_b = wd;
    end else begin
      rd_b = regs_q[rb];
    end
  end
`else
  always_comb begin
    rd_a = regs_q[ra];
    rd_b = regs_q[rb];
  end
`endif

endmodule

// File: tb/tb_reg_file_8x8.sv
// Directed self-checking bench for reg_file_8x8 with hand-computed expectations.
module tb_reg_file_8x8;

  logic       clk;
  logic       rst;
  logic [2:0] ra;
  logic [2:0] rb;
  logic [2:0] wa;
  logic       we;
  logic [7:0] wd;
  logic [7:0] rd_a;
  logic [7:0] rd_b;

  int n_checks;
  int n_pass;

  reg_file_8x8 #(.DATA_W(8), .ADDR_W(3)) dut (
    .clk  (clk),
    .rst  (rst),
    .ra   (ra),
    .rb   (rb),
    .wa   (wa),
    .we   (we),
    .wd   (wd),
    .rd_a (rd_a),
    .rd_b (rd_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    we = 1'b1;
    wa = a;
    wd = d;
    tick();
    we = 1'b0;
  endtask

  initial begin
    logic [7:0] rdw_exp;
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1; we = 1'b0; wa = 3'd0; wd = 8'h00; ra = 3'd0; rb = 3'd0;
    tick();
    rst = 1'b0;
    #1;
    check("reset_ra0", rd_a, 8'h00);

    // Fill with FF, then clear with a single reset edge.
    for (int i = 0; i < 8; i++) wr(3'(i), 8'hFF);
    ra = 3'd7; rb = 3'd0;
    #1;
    check("fill_r7", rd_a, 8'hFF);
    check("fill_r0", rd_b, 8'hFF);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ra = 3'(i);
      rb = 3'(7 - i);
      #1;
      check("clear_a", rd_a, 8'h00);
      check("clear_b", rd_b, 8'h00);
    end

    // Single write, others untouched.
    wr(3'd3, 8'h55);
    ra = 3'd3;
    #1;
    check("single_r3", rd_a, 8'h55);
    for (int i = 0; i < 8; i++) begin
      if (i != 3) begin
        rb = 3'(i);
        #1;
        check("single_other", rd_b, 8'h00);
      end
    end

    // Read during write.
`ifdef REGFILE_BYPASS_EN
    rdw_exp = 8'hAA;
`else
    rdw_exp = 8'h00;
`endif
    we = 1'b1; wa = 3'd5; wd = 8'hAA; ra = 3'd5; rb = 3'd5;
    #1;
    check("rdw_pre_a", rd_a, rdw_exp);
    check("rdw_pre_b", rd_b, rdw_exp);
    tick();
    we = 1'b0;
    #1;
    check("rdw_post_a", rd_a, 8'hAA);
    check("rdw_post_b", rd_b, 8'hAA);

    // Write-enable gating.
    wr(3'd2, 8'h12);
    we = 1'b0; wa = 3'd2; wd = 8'h99; ra = 3'd2;
    tick();
    check("we_gate_r2", rd_a, 8'h12);

    // Dual port.
    wr(3'd1, 8'h11);
    wr(3'd6, 8'h66);
    ra = 3'd1; rb = 3'd6;
    #1;
    check("dual_a_r1", rd_a, 8'h11);
    check("dual_b_r6", rd_b, 8'h66);
    ra = 3'd6;
    #1;
    check("same_a_r6", rd_a, 8'h66);
    check("same_b_r6", rd_b, 8'h66);

    // Back-to-back writes to R0; last value wins, R0 is writable.
    wr(3'd0, 8'h01);
    wr(3'd0, 8'h02);
    wr(3'd7, 8'h77);
    ra = 3'd0; rb = 3'd7;
    #1;
    check("b2b_r0", rd_a, 8'h02);
    check("b2b_r7", rd_b, 8'h77);

    // Reset priority: bypass inactive under reset, write dropped, all cleared.
    wr(3'd4, 8'h4C);
    rst = 1'b1; we = 1'b1; wa = 3'd4; wd = 8'h44; ra = 3'd4; rb = 3'd5;
    #1;
    check("rstpri_pre_r4", rd_a, 8'h4C);
    tick();
    check("rstpri_held_r4", rd_a, 8'h00);
    check("rstpri_held_r5", rd_b, 8'h00);
    tick();
    check("rst2_r4", rd_a, 8'h00);
    rst = 1'b0;
    tick();
    we = 1'b0;
    #1;
    check("rst_release_write_r4", rd_a, 8'h44);
    check("rst_lost_r5", rd_b, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
